// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-stage bundle: hazard/branch inputs, instruction-memory port and the IF/ID latch outputs.
// The slave modport is the fetch controller; the master modport drives it.
interface fetch_stall_ctrl_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
);
    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic              ex_bubble;
    logic [1:0]        state;
    logic [1:0]        stall_cnt;
    logic              stall_err;

    modport master (
        output stall, br_taken, br_target, imem_data,
        input  imem_addr, id_pc, id_inst, id_valid, ex_bubble, state, stall_cnt, stall_err
    );

    modport slave (
        input  stall, br_taken, br_target, imem_data,
        output imem_addr, id_pc, id_inst, id_valid, ex_bubble, state, stall_cnt, stall_err
    );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID latch with stall hold, taken-branch redirect/squash,
// bubble request toward ID/EX and a sticky detector for over-long stalls.
module fetch_stall_ctrl #(
    parameter int              PC_W      = 16,
    parameter int              INST_W    = 16,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INST_W-1:0] NOP_INST  = '0,
    parameter int              STALL_MAX = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fetch_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    localparam logic [1:0] CNT_SAT      = 2'd3;
    localparam logic [1:0] STALL_ERR_AT = 2'(STALL_MAX - 1);

    logic [PC_W-1:0]   pc_q,        pc_d;
    logic [PC_W-1:0]   id_pc_q,     id_pc_d;
    logic [INST_W-1:0] id_inst_q,   id_inst_d;
    logic              id_valid_q,  id_valid_d;
    state_e            state_q,     state_d;
    logic [1:0]        stall_cnt_q, stall_cnt_d;
    logic              stall_err_q, stall_err_d;

    always_comb begin
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;

        if (bus.stall) begin
            // Everything in fetch freezes; a branch in ID re-resolves once the stall drops.
            state_d     = ST_STALLED;
            stall_cnt_d = (stall_cnt_q == CNT_SAT) ? CNT_SAT : stall_cnt_q + 2'd1;
            if (stall_cnt_q == STALL_ERR_AT) begin
                stall_err_d = 1'b1;
            end
        end else begin
            stall_cnt_d = 2'd0;
            if (bus.br_taken && id_valid_q) begin
                // The word fetched this cycle is on the wrong path: squash it.
                pc_d       = bus.br_target;
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
                state_d    = ST_FLUSH;
            end else begin
                pc_d       = pc_q + 1'b1;
                id_inst_d  = bus.imem_data;
                id_pc_d    = pc_q;
                id_valid_d = 1'b1;
                state_d    = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
            state_q     <= ST_BOOT;
            stall_cnt_q <= 2'd0;
            stall_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Bubble request is combinational so ID/EX sees it in the same cycle as the stall.
    assign bus.ex_bubble = bus.stall | ~id_valid_q;
    assign bus.imem_addr = pc_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.stall_err = stall_err_q;
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: one instance with RESET_PC=0 for the main scenarios,
// a second with RESET_PC=0xFFFF for PC wrap-around. Instruction memory returns address+0x100.
module tb_fetch_stall_ctrl;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_stall_ctrl_if #(.PC_W(16), .INST_W(16)) bus0 ();
    fetch_stall_ctrl_if #(.PC_W(16), .INST_W(16)) bus1 ();

    assign bus0.imem_data = bus0.imem_addr + 16'h0100;
    assign bus1.imem_data = bus1.imem_addr + 16'h0100;

    fetch_stall_ctrl #(
        .PC_W(16), .INST_W(16), .RESET_PC(16'h0000), .NOP_INST(16'h0000), .STALL_MAX(3)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0.slave)
    );

    fetch_stall_ctrl #(
        .PC_W(16), .INST_W(16), .RESET_PC(16'hFFFF), .NOP_INST(16'h0000), .STALL_MAX(3)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [15:0] addr, input logic [15:0] ipc,
                        input logic [15:0] inst, input logic vld, input logic [1:0] st,
                        input logic [1:0] cnt, input logic err);
        check({tag, ".addr"},  32'(bus0.imem_addr), 32'(addr));
        check({tag, ".idpc"},  32'(bus0.id_pc),     32'(ipc));
        check({tag, ".inst"},  32'(bus0.id_inst),   32'(inst));
        check({tag, ".valid"}, 32'(bus0.id_valid),  32'(vld));
        check({tag, ".state"}, 32'(bus0.state),     32'(st));
        check({tag, ".cnt"},   32'(bus0.stall_cnt), 32'(cnt));
        check({tag, ".err"},   32'(bus0.stall_err), 32'(err));
        $display("step %s addr=%h id_pc=%h inst=%h valid=%0d state=%0d cnt=%0d err=%0d bubble=%0d",
                 tag, bus0.imem_addr, bus0.id_pc, bus0.id_inst, bus0.id_valid,
                 bus0.state, bus0.stall_cnt, bus0.stall_err, bus0.ex_bubble);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.stall = 1'b0; bus0.br_taken = 1'b0; bus0.br_target = 16'h0000;
        bus1.stall = 1'b0; bus1.br_taken = 1'b0; bus1.br_target = 16'h0000;
        tick();
        tick();

        // Reset state, both instances
        chk0("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0);
        check("rst.bubble", 32'(bus0.ex_bubble), 32'd1);
        check("wrap.rst_addr", 32'(bus1.imem_addr), 32'h0000FFFF);
        rst0 = 1'b0; rst1 = 1'b0;

        // Free run: fetch latency of one edge
        tick();
        chk0("run1", 16'h0001, 16'h0000, 16'h0100, 1'b1, 2'd1, 2'd0, 1'b0);
        check("run1.bubble", 32'(bus0.ex_bubble), 32'd0);
        check("wrap.addr1", 32'(bus1.imem_addr), 32'h00000000);
        check("wrap.idpc1", 32'(bus1.id_pc),     32'h0000FFFF);
        check("wrap.inst1", 32'(bus1.id_inst),   32'h000000FF);
        tick();
        chk0("run2", 16'h0002, 16'h0001, 16'h0101, 1'b1, 2'd1, 2'd0, 1'b0);
        check("wrap.addr2", 32'(bus1.imem_addr), 32'h00000001);
        check("wrap.idpc2", 32'(bus1.id_pc),     32'h00000000);
        tick();
        chk0("run3", 16'h0003, 16'h0002, 16'h0102, 1'b1, 2'd1, 2'd0, 1'b0);
        tick();
        chk0("run4", 16'h0004, 16'h0003, 16'h0103, 1'b1, 2'd1, 2'd0, 1'b0);
        tick();
        chk0("run5", 16'h0005, 16'h0004, 16'h0104, 1'b1, 2'd1, 2'd0, 1'b0);

        // Single-cycle stall at PC=5
        bus0.stall = 1'b1;
        #1;
        check("stall1.bubble_comb", 32'(bus0.ex_bubble), 32'd1);
        tick();
        chk0("stall1", 16'h0005, 16'h0004, 16'h0104, 1'b1, 2'd2, 2'd1, 1'b0);
        bus0.stall = 1'b0;
        #1;
        check("stall1.bubble_drop", 32'(bus0.ex_bubble), 32'd0);
        tick();
        chk0("resume", 16'h0006, 16'h0005, 16'h0105, 1'b1, 2'd1, 2'd0, 1'b0);
        tick();
        chk0("run7", 16'h0007, 16'h0006, 16'h0106, 1'b1, 2'd1, 2'd0, 1'b0);

        // Taken branch at PC=7 to 0x40
        bus0.br_taken = 1'b1; bus0.br_target = 16'h0040;
        tick();
        bus0.br_taken = 1'b0;
        #1;
        chk0("branch", 16'h0040, 16'h0006, 16'h0000, 1'b0, 2'd3, 2'd0, 1'b0);
        check("branch.bubble", 32'(bus0.ex_bubble), 32'd1);
        tick();
        chk0("post_br", 16'h0041, 16'h0040, 16'h0140, 1'b1, 2'd1, 2'd0, 1'b0);

        // Stall and branch together twice, then branch alone
        bus0.stall = 1'b1; bus0.br_taken = 1'b1; bus0.br_target = 16'h0080;
        tick();
        chk0("sb1", 16'h0041, 16'h0040, 16'h0140, 1'b1, 2'd2, 2'd1, 1'b0);
        tick();
        chk0("sb2", 16'h0041, 16'h0040, 16'h0140, 1'b1, 2'd2, 2'd2, 1'b0);
        bus0.stall = 1'b0;
        tick();
        chk0("sb_redir", 16'h0080, 16'h0040, 16'h0000, 1'b0, 2'd3, 2'd0, 1'b0);

        // Branch while ID holds a bubble is ignored
        bus0.br_target = 16'h0020;
        tick();
        bus0.br_taken = 1'b0;
        #1;
        chk0("br_bubble", 16'h0081, 16'h0080, 16'h0180, 1'b1, 2'd1, 2'd0, 1'b0);

        // Over-long stall: error on third consecutive stall edge, count saturates
        bus0.stall = 1'b1;
        tick();
        chk0("ovr1", 16'h0081, 16'h0080, 16'h0180, 1'b1, 2'd2, 2'd1, 1'b0);
        tick();
        chk0("ovr2", 16'h0081, 16'h0080, 16'h0180, 1'b1, 2'd2, 2'd2, 1'b0);
        tick();
        chk0("ovr3", 16'h0081, 16'h0080, 16'h0180, 1'b1, 2'd2, 2'd3, 1'b1);
        tick();
        chk0("ovr4", 16'h0081, 16'h0080, 16'h0180, 1'b1, 2'd2, 2'd3, 1'b1);
        bus0.stall = 1'b0;
        tick();
        chk0("sticky1", 16'h0082, 16'h0081, 16'h0181, 1'b1, 2'd1, 2'd0, 1'b1);
        tick();
        chk0("sticky2", 16'h0083, 16'h0082, 16'h0182, 1'b1, 2'd1, 2'd0, 1'b1);

        // Reset mid-stall with branch asserted: reset wins
        bus0.stall = 1'b1;
        tick();
        rst0 = 1'b1; bus0.br_taken = 1'b1; bus0.br_target = 16'h0055;
        tick();
        chk0("rst_mid", 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0);
        rst0 = 1'b0; bus0.stall = 1'b0; bus0.br_taken = 1'b0;
        tick();
        chk0("after_rst", 16'h0001, 16'h0000, 16'h0100, 1'b1, 2'd1, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
